ps2_frame_rx: RTL
=================

// Module: ps2_frame_rx
// PURPOSE
//  Sequential PS/2 receiver, parametrised successor to the combinational frame checker.
//  Synchronises raw ps2_clk/ps2_data, shifts in start/data/parity/stop bits on ps2_clk
//  falling edges, then checks parity (configurable mode) and start/stop framing.
//  Also enforces an inter-edge timeout. Good frames go to a small FWFT FIFO read by
//  the keyboard decoder.
// PARAMETERS
//  DATA_W       8     data bits per frame, LSB first (1..16)
//  PARITY_MODE  1     0 = none (no parity bit), 1 = odd, 2 = even
//  SYNC_STAGES  2     flops in each input synchroniser (>=2)
//  TIMEOUT_CYC  5000  max clk cycles between ps2_clk falling edges inside a frame
//  FIFO_DEPTH   4     output FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous reset, active-low
//  ps2_clk      in   1       raw PS/2 clock line (async)
//  ps2_data     in   1       raw PS/2 data line (async)
//  rd_en        in   1       pop FIFO head; ignored when valid=0
//  dout         out  DATA_W  FIFO head data (first-word fall-through)
//  valid        out  1       FIFO non-empty
//  full         out  1       FIFO holds FIFO_DEPTH entries
//  err_parity   out  1       1-cycle pulse: parity check failed, frame dropped
//  err_frame    out  1       1-cycle pulse: start!=0 or stop!=1, frame dropped
//  err_timeout  out  1       1-cycle pulse: edge gap > TIMEOUT_CYC, frame aborted
//  overflow     out  1       sticky: good frame dropped because FIFO full
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, FIFO empty, shift reg/counters 0. Reset mid-frame
//    discards the partial frame; the sticky overflow flag clears only on reset.
//  - Edge detect: fall = sync_clk_q & ~sync_clk; data is sampled from sync_data that cycle.
//  - FSM, one transition per fall:
//      IDLE -> DATA; start bit is captured. A start bit of 1 is not rejected here:
//        it is checked at STOP with the rest of the frame.
//      DATA -> bit counter 0..DATA_W-1; at DATA_W-1 go to PARITY
//        (or STOP if PARITY_MODE=0).
//      PARITY -> STOP.
//      STOP -> CHECK (one clk, no fall needed) -> IDLE.
//  - CHECK rules:
//      odd  = ^{data,par}==1; even = ^{data,par}==0; none = always pass.
//      Framing pass = (start==0 && stop==1).
//      Framing fail: err_frame pulses. Otherwise parity fail: err_parity pulses.
//      Only one error pulse per frame; framing has priority.
//      Both pass: push data to FIFO if not full, else drop and set overflow.
//  - Timeout: gap counter clears on every fall and holds 0 in IDLE. Outside IDLE,
//    reaching TIMEOUT_CYC pulses err_timeout and forces IDLE with no push.
//    Counter width = $clog2(TIMEOUT_CYC+1).
//  - Latency: valid/dout update SYNC_STAGES+2 clk after the raw stop-bit falling edge.
//  - FIFO:
//      Pop when rd_en && valid; dout shows the new head next cycle.
//      Push and pop in the same cycle are both performed, including when full
//        (no overflow).
//      rd_en while empty: no effect.
//      Pointers wrap modulo FIFO_DEPTH; an extra count bit distinguishes full from empty.
//  - Glitch immunity: a fall is recognised only after the synchroniser; an edge
//    shorter than 1 clk may be missed. That is allowed; the timeout recovers.
// CONFIGURATION
//  PS2_ERR_COUNT_EN defined:
//    - Adds output err_cnt [7:0]: saturating count (stops at 255) of all err_* pulses.
//    - Cleared by reset only. Two pulses cannot occur in the same cycle.
//  PS2_ERR_COUNT_EN undefined:
//    - Port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Odd mode, frame 0x1C:
//     start 0, bits 0,0,1,1,1,0,0,0, par 0, stop 1.
//     -> valid=1, dout=8'h1C; no err pulses.
//  2. Same frame, par=1 -> err_parity pulses once; valid stays 0.
//  3. 0x1C frame with stop=0 -> err_frame pulses; err_parity stays low; FIFO unchanged.
//  4. Send start plus 4 data bits, then hold ps2_clk high > TIMEOUT_CYC
//     -> err_timeout pulses.
//     A following full 0xF0 frame -> dout=8'hF0.
//  5. Five good frames 0x01..0x05 with FIFO_DEPTH=4 and no reads:
//     -> full=1, overflow=1.
//     Reads then return 01,02,03,04; valid drops after the 4th pop.
//  6. PARITY_MODE=2, DATA_W=8, frame 0xAA (par 0) -> dout=8'hAA.
//     Assert reset_n=0 mid-frame -> all outputs 0; the next frame is received cleanly.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronise, shift in start/data/parity/stop, check, queue in an FWFT FIFO.
// Define PS2_ERR_COUNT_EN to add the saturating err_cnt output.
module ps2_frame_rx #(
   parameter int DATA_W      = 8,
   parameter int PARITY_MODE = 1,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 5000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              full,
   output logic              err_parity,
   output logic              err_frame,
   output logic              err_timeout,
   output logic              overflow
`ifdef PS2_ERR_COUNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int GW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_CHECK} state_t;

   state_t                          state, state_d;
   logic [SYNC_STAGES-1:0]          clk_sh, data_sh;
   logic                            sync_clk, sync_data, sync_clk_q, fall;
   logic [GW-1:0]                   gap_cnt;
   logic                            timeout;
   logic [CW-1:0]                   bit_cnt;
   logic [DATA_W-1:0]               shift_q;
   logic                            start_bit, par_bit, stop_bit;
   logic                            frame_ok, par_ok, push_req;
   logic                            err_parity_d, err_frame_d;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
   logic [AW-1:0]                   wr_ptr, rd_ptr;
   logic [AW:0]                     count;
   logic                            push, pop;

   assign sync_clk  = clk_sh[SYNC_STAGES-1];
   assign sync_data = data_sh[SYNC_STAGES-1];
   assign fall      = sync_clk_q & ~sync_clk;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sh     <= '0;
         data_sh    <= '0;
         sync_clk_q <= 1'b0;
      end else begin
         clk_sh     <= {clk_sh[SYNC_STAGES-2:0], ps2_clk};
         data_sh    <= {data_sh[SYNC_STAGES-2:0], ps2_data};
         sync_clk_q <= sync_clk;
      end
   end

   // Gap counter saturates at the limit; the limit itself is the abort condition.
   assign timeout = (state inside {S_DATA, S_PARITY, S_STOP}) && (gap_cnt == GW'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        gap_cnt <= '0;
      else if (state == S_IDLE || fall)    gap_cnt <= '0;
      else if (gap_cnt != GW'(TIMEOUT_CYC)) gap_cnt <= gap_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (timeout) state_d = S_IDLE;
      else begin
         case (state)
            S_IDLE:   if (fall) state_d = S_DATA;
            S_DATA:   if (fall && bit_cnt == CW'(DATA_W - 1))
                         state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
            S_PARITY: if (fall) state_d = S_STOP;
            S_STOP:   if (fall) state_d = S_CHECK;
            S_CHECK:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_bit <= 1'b0;
         par_bit   <= 1'b0;
         stop_bit  <= 1'b0;
         bit_cnt   <= '0;
         shift_q   <= '0;
      end else if (fall && !timeout) begin
         case (state)
            S_IDLE: begin
               start_bit <= sync_data;
               bit_cnt   <= '0;
            end
            S_DATA: begin
               shift_q[bit_cnt] <= sync_data;
               bit_cnt          <= bit_cnt + 1'b1;
            end
            S_PARITY: par_bit  <= sync_data;
            S_STOP:   stop_bit <= sync_data;
            default: ;
         endcase
      end
   end

   // Framing failure masks the parity result so each bad frame gives one pulse.
   always_comb begin
      frame_ok = !start_bit && stop_bit;
      par_ok   = 1'b1;
      if (PARITY_MODE == 1) par_ok = ^{shift_q, par_bit};
      if (PARITY_MODE == 2) par_ok = ~^{shift_q, par_bit};
      push_req     = (state == S_CHECK) && frame_ok && par_ok;
      err_frame_d  = (state == S_CHECK) && !frame_ok;
      err_parity_d = (state == S_CHECK) && frame_ok && !par_ok;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_parity  <= 1'b0;
         err_frame   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         err_parity  <= err_parity_d;
         err_frame   <= err_frame_d;
         err_timeout <= timeout;
      end
   end

   assign valid = (count != '0);
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign pop   = rd_en && valid;
   assign push  = push_req && (!full || pop);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= shift_q;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

`ifdef PS2_ERR_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_cnt <= '0;
      else if ((err_parity || err_frame || err_timeout) && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 1'b1;
   end
`endif

endmodule
